combiner: RTL and testbench

Packs a stream of 16-bit elements, P per beat, into 512-bit memory write words for the DDR write path, MSB lane first. It also reports the element count of each message it packs. It sits between the compute/operation pipeline and the memory write interface, and performs the inverse transform of the read-side element splitter. All packing is done at `ui_clk` rate with valid/ready backpressure on both sides.

---
 rtl/mpi_pkg.sv | 13 +
 rtl/combiner_if.sv | 29 ++
 rtl/word_outreg.sv | 40 ++++
 rtl/combiner.sv | 164 ++++++++++++++++
 tb/tb_combiner.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mpi_pkg.sv
// Shared constants and state type for the DDR write-side packer and the
// read-side element splitter.
package mpi_pkg;
    localparam int WORD_W = 512;   // memory word width
    localparam int ELEM_W = 16;    // element width
    localparam int SIZE_W = 16;    // message element-count width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        HOLD = 2'd2
    } comb_state_t;
endpackage

// File: rtl/combiner_if.sv
// Input beat stream plus packed output word stream of the combiner.
// The combiner uses the slave view; the producer/consumer side uses master.
interface combiner_if #(
    parameter int P = 1
);
    import mpi_pkg::*;

    logic [ELEM_W*P-1:0] idata;
    logic                ivalid;
    logic                istart;
    logic                ilast;
    logic                iready;
    logic [WORD_W-1:0]   wdata;
    logic                wvalid;
    logic                wlast;
    logic                wready;
    logic [SIZE_W-1:0]   msize;
    logic                msvalid;

    modport slave (
        input  idata, ivalid, istart, ilast, wready,
        output iready, wdata, wvalid, wlast, msize, msvalid
    );

    modport master (
        output idata, ivalid, istart, ilast, wready,
        input  iready, wdata, wvalid, wlast, msize, msvalid
    );
endinterface

// File: rtl/word_outreg.sv
// Single-entry output register for packed words. It can accept a new word
// in the same cycle the current one is taken downstream.
module word_outreg
    import mpi_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic              o_last,
    output logic              o_free
);
    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic              r_last;

    // Load a new word, or empty the register once the current word is taken.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
endmodule

// File: rtl/combiner.sv
// Packs P 16-bit elements per beat into 512-bit write words, MSB lane
// first, and reports the element count of every completed message.
module combiner
    import mpi_pkg::*;
#(
    parameter int P = 1
) (
    input  logic     ui_clk,
    input  logic     reset,
    combiner_if.slave bus
);
    localparam int DW     = ELEM_W * P;
    localparam int LANES  = WORD_W / DW;
    localparam int LCNT_W = $clog2(LANES) + 1;

    comb_state_t       r_state, w_state_next;
    logic [WORD_W-1:0] r_acc, w_acc_next;
    logic [LCNT_W-1:0] r_lane, w_lane_next;
    logic [SIZE_W-1:0] r_elem, w_elem_next;
    logic [SIZE_W-1:0] r_msize, w_msize_next;
    logic              r_msvalid, w_msvalid_next;
    logic              r_hold_last, w_hold_last_next;
    logic              r_iready;

    logic              w_take;
    logic [WORD_W-1:0] w_acc_base;
    logic [WORD_W-1:0] w_acc_wr;
    logic [LCNT_W-1:0] w_lane_idx;
    logic [SIZE_W-1:0] w_elem_sum;
    logic              w_word_done;
    logic              w_load;
    logic [WORD_W-1:0] w_load_data;
    logic              w_load_last;
    logic              w_free;
    logic              w_wvalid;
    logic [WORD_W-1:0] w_wdata;
    logic              w_wlast;

    // A start beat always opens a fresh word (also aborting a message in
    // progress); other beats only count while a message is open.
    assign w_take      = bus.ivalid && r_iready && (bus.istart || r_state == PACK);
    assign w_acc_base  = bus.istart ? '0 : r_acc;
    assign w_lane_idx  = bus.istart ? '0 : r_lane;
    assign w_elem_sum  = (bus.istart ? '0 : r_elem) + SIZE_W'(P);
    assign w_word_done = (w_lane_idx == LCNT_W'(LANES - 1)) || bus.ilast;

    // Accumulator with the current beat dropped into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_acc_wr[WORD_W-1-DW*gi -: DW] =
                (w_lane_idx == LCNT_W'(gi)) ? bus.idata
                                            : w_acc_base[WORD_W-1-DW*gi -: DW];
        end
    endgenerate

    // Next-state, accumulator and output-register load decisions.
    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_lane_next      = r_lane;
        w_elem_next      = r_elem;
        w_msize_next     = r_msize;
        w_msvalid_next   = 1'b0;
        w_hold_last_next = r_hold_last;
        w_load           = 1'b0;
        w_load_data      = r_acc;
        w_load_last      = r_hold_last;
        case (r_state)
            IDLE, PACK: begin
                if (w_take) begin
                    if (w_word_done) begin
                        w_lane_next = '0;
                        if (w_free) begin
                            w_load      = 1'b1;
                            w_load_data = w_acc_wr;
                            w_load_last = bus.ilast;
                            w_acc_next  = '0;
                            if (bus.ilast) begin
                                w_msize_next   = w_elem_sum;
                                w_msvalid_next = 1'b1;
                                w_elem_next    = '0;
                                w_state_next   = IDLE;
                            end else begin
                                w_elem_next  = w_elem_sum;
                                w_state_next = PACK;
                            end
                        end else begin
                            // Output register busy: park the word in acc.
                            w_acc_next       = w_acc_wr;
                            w_elem_next      = w_elem_sum;
                            w_hold_last_next = bus.ilast;
                            w_state_next     = HOLD;
                        end
                    end else begin
                        w_acc_next   = w_acc_wr;
                        w_lane_next  = w_lane_idx + 1'b1;
                        w_elem_next  = w_elem_sum;
                        w_state_next = PACK;
                    end
                end
            end
            HOLD: begin
                if (w_free) begin
                    w_load     = 1'b1;
                    w_acc_next = '0;
                    if (r_hold_last) begin
                        w_msize_next   = r_elem;
                        w_msvalid_next = 1'b1;
                        w_elem_next    = '0;
                        w_state_next   = IDLE;
                    end else begin
                        w_state_next = PACK;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and counter registers; iready is registered from the next state
    // so it never depends combinationally on wready.
    always_ff @(posedge ui_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_lane      <= '0;
            r_elem      <= '0;
            r_msize     <= '0;
            r_msvalid   <= 1'b0;
            r_hold_last <= 1'b0;
            r_iready    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_lane      <= w_lane_next;
            r_elem      <= w_elem_next;
            r_msize     <= w_msize_next;
            r_msvalid   <= w_msvalid_next;
            r_hold_last <= w_hold_last_next;
            r_iready    <= (w_state_next != HOLD);
        end
    end

    word_outreg u_outreg (
        .clk     (ui_clk),
        .srst    (reset),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_last  (w_load_last),
        .i_ready (bus.wready),
        .o_valid (w_wvalid),
        .o_data  (w_wdata),
        .o_last  (w_wlast),
        .o_free  (w_free)
    );

    assign bus.iready  = r_iready;
    assign bus.wvalid  = w_wvalid;
    assign bus.wdata   = w_wdata;
    assign bus.wlast   = w_wlast;
    assign bus.msize   = r_msize;
    assign bus.msvalid = r_msvalid;
endmodule

// File: tb/tb_combiner.sv
// Scoreboard bench for the combiner with P=1, P=2 and P=4 instances.
module tb_combiner;
    import mpi_pkg::*;

    logic ui_clk = 1'b0;
    logic reset  = 1'b1;
    always #5 ui_clk = ~ui_clk;

    combiner_if #(.P(1)) bus1();
    combiner_if #(.P(2)) bus2();
    combiner_if #(.P(4)) bus4();

    combiner #(.P(1)) u_dut1 (.ui_clk(ui_clk), .reset(reset), .bus(bus1.slave));
    combiner #(.P(2)) u_dut2 (.ui_clk(ui_clk), .reset(reset), .bus(bus2.slave));
    combiner #(.P(4)) u_dut4 (.ui_clk(ui_clk), .reset(reset), .bus(bus4.slave));

    typedef struct packed {
        logic [1:0]        sel;
        logic              last;
        logic [WORD_W-1:0] data;
    } exp_word_t;

    typedef struct packed {
        logic [1:0]        sel;
        logic [SIZE_W-1:0] size;
    } exp_size_t;

    exp_word_t q_word[$];
    exp_size_t q_size[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_stalls = 0;

    // Transaction-level reference state per instance (sel 0/1/2 -> P 1/2/4)
    logic [WORD_W-1:0] m_acc[3];
    int                m_lane[3];
    int                m_elem[3];
    bit                m_active[3];

    task automatic chk(input string tag, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_acc[s] = '0; m_lane[s] = 0; m_elem[s] = 0; m_active[s] = 1'b0;
        end
    endtask

    // Reference behaviour of one accepted beat: place elements, emit words.
    task automatic model_beat(input int sel, input logic [WORD_W-1:0] d, input bit st, input bit la);
        int p;
        logic [WORD_W-1:0] a;
        exp_word_t w;
        exp_size_t s;
        p = 1 << sel;
        if (!m_active[sel] && !st) return;
        if (st) begin
            m_acc[sel] = '0; m_lane[sel] = 0; m_elem[sel] = 0; m_active[sel] = 1'b1;
        end
        a = m_acc[sel];
        for (int k = 0; k < p; k++)
            a[WORD_W-1-ELEM_W*(p*m_lane[sel]+k) -: ELEM_W] = d[ELEM_W*p-1-ELEM_W*k -: ELEM_W];
        m_lane[sel]++;
        m_elem[sel] = (m_elem[sel] + p) & 16'hFFFF;
        if (m_lane[sel] == 32 / p || la) begin
            w.sel = 2'(sel); w.last = la; w.data = a;
            q_word.push_back(w);
            a = '0;
            m_lane[sel] = 0;
            if (la) begin
                s.sel = 2'(sel); s.size = 16'(m_elem[sel]);
                q_size.push_back(s);
                m_active[sel] = 1'b0;
                m_elem[sel] = 0;
            end
        end
        m_acc[sel] = a;
    endtask

    task automatic drive(input int sel, input bit v, input logic [WORD_W-1:0] d, input bit st, input bit la);
        case (sel)
            0: begin bus1.ivalid = v; bus1.idata = d[15:0]; bus1.istart = st; bus1.ilast = la; end
            1: begin bus2.ivalid = v; bus2.idata = d[31:0]; bus2.istart = st; bus2.ilast = la; end
            default: begin bus4.ivalid = v; bus4.idata = d[63:0]; bus4.istart = st; bus4.ilast = la; end
        endcase
    endtask

    function automatic logic get_iready(input int sel);
        case (sel)
            0: return bus1.iready;
            1: return bus2.iready;
            default: return bus4.iready;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input int sel, input logic [WORD_W-1:0] d, input bit st, input bit la);
        int wait_cnt;
        wait_cnt = 0;
        drive(sel, 1'b1, d, st, la);
        while (!get_iready(sel) && wait_cnt < 500) begin
            @(negedge ui_clk);
            wait_cnt++;
            n_stalls++;
        end
        if (wait_cnt >= 500) chk("iready_timeout", get_iready(sel), 1);
        else model_beat(sel, d, st, la);
        @(negedge ui_clk);
        drive(sel, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_msg(input int sel, input int nbeats, input int base, input bit st_first, input bit la_end);
        int p;
        logic [WORD_W-1:0] d;
        p = 1 << sel;
        for (int b = 0; b < nbeats; b++) begin
            d = '0;
            for (int k = 0; k < p; k++) d[ELEM_W*p-1-ELEM_W*k -: ELEM_W] = 16'(base + b*p + k);
            send_beat(sel, d, st_first && (b == 0), la_end && (b == nbeats - 1));
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_word.size() != 0 || q_size.size() != 0) && n < 1000) begin
            @(negedge ui_clk);
            n++;
        end
        chk(tag, q_word.size() + q_size.size(), 0);
        repeat (3) @(negedge ui_clk);
    endtask

    task automatic mon_word(input int sel, input logic [WORD_W-1:0] data, input logic last);
        exp_word_t e;
        $display("word dut_sel=%0d last=%0b top=%h low=%h", sel, last, data[511:480], data[31:0]);
        if (q_word.size() == 0) begin
            chk("unexpected_word", q_word.size(), 1);
        end else begin
            e = q_word.pop_front();
            chk("word_sel", sel, e.sel);
            chk("word_data", data, e.data);
            chk("word_last", last, e.last);
        end
    endtask

    task automatic mon_size(input int sel, input logic [SIZE_W-1:0] size);
        exp_size_t e;
        $display("msize dut_sel=%0d size=%0d", sel, size);
        if (q_size.size() == 0) begin
            chk("unexpected_msvalid", q_size.size(), 1);
        end else begin
            e = q_size.pop_front();
            chk("msize_sel", sel, e.sel);
            chk("msize", size, e.size);
        end
    endtask

    // Output monitor: a handshake completes at the next rising edge.
    always @(negedge ui_clk) begin
        if (!reset) begin
            if (bus1.wvalid && bus1.wready) mon_word(0, bus1.wdata, bus1.wlast);
            if (bus2.wvalid && bus2.wready) mon_word(1, bus2.wdata, bus2.wlast);
            if (bus4.wvalid && bus4.wready) mon_word(2, bus4.wdata, bus4.wlast);
            if (bus1.msvalid) mon_size(0, bus1.msize);
            if (bus2.msvalid) mon_size(1, bus2.msize);
            if (bus4.msvalid) mon_size(2, bus4.msize);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, 1'b0, 1'b0);
        bus1.wready = 1'b1; bus2.wready = 1'b1; bus4.wready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge ui_clk);

        // Reset state
        chk("rst_iready", bus1.iready, 0);
        chk("rst_wvalid", bus1.wvalid, 0);
        chk("rst_wdata", bus1.wdata, 0);
        chk("rst_wlast", bus1.wlast, 0);
        chk("rst_msize", bus1.msize, 0);
        chk("rst_msvalid", bus1.msvalid, 0);
        reset = 1'b0;
        @(negedge ui_clk);
        chk("post_rst_iready1", bus1.iready, 1);
        chk("post_rst_iready2", bus2.iready, 1);
        chk("post_rst_iready4", bus4.iready, 1);

        // P=1, 64 elements: two words, full throughput
        n_stalls = 0;
        send_msg(0, 64, 16'h0001, 1'b1, 1'b1);
        chk("p1_throughput_stalls", n_stalls, 0);
        drain("p1_64_drain");

        // P=4, 10 beats: one full word plus a two-lane last word
        send_msg(2, 10, 16'h0101, 1'b1, 1'b1);
        drain("p4_40_drain");

        // P=2, single-beat message
        send_beat(1, 512'hAAAA5555, 1'b1, 1'b1);
        drain("p2_single_drain");

        // P=1, 96 elements with downstream stalled
        @(posedge ui_clk); #1 bus1.wready = 1'b0;
        @(negedge ui_clk);
        fork
            send_msg(0, 96, 16'h1001, 1'b1, 1'b1);
            begin
                repeat (80) @(negedge ui_clk);
                chk("hold_iready", bus1.iready, 0);
                chk("hold_wvalid", bus1.wvalid, 1);
                chk("hold_wdata_lane0", bus1.wdata[511:496], 16'h1001);
                chk("hold_wlast", bus1.wlast, 0);
                @(posedge ui_clk); #1 bus1.wready = 1'b1;
            end
        join
        drain("p1_96_drain");

        // Junk before start, truncated message, then a 3-element message
        for (int j = 0; j < 3; j++) send_beat(0, 512'hDEAD, 1'b0, 1'b0);
        send_msg(0, 5, 16'h0100, 1'b1, 1'b0);
        send_msg(0, 3, 16'h0200, 1'b1, 1'b1);
        drain("restart_drain");

        // Reset mid-message, then a clean 32-element message
        send_msg(0, 10, 16'h0300, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge ui_clk);
        chk("midrst_iready", bus1.iready, 0);
        chk("midrst_wvalid", bus1.wvalid, 0);
        chk("midrst_wdata", bus1.wdata, 0);
        chk("midrst_msize", bus1.msize, 0);
        chk("midrst_msvalid", bus1.msvalid, 0);
        model_reset();
        reset = 1'b0;
        @(negedge ui_clk);
        send_msg(0, 32, 16'h0401, 1'b1, 1'b1);
        drain("post_rst_32_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
